// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity encodings and helpers
package uart_pkg;

    typedef enum logic [2:0] {
        UART_TX_IDLE  = 3'd0,
        UART_TX_START = 3'd1,
        UART_TX_DATA  = 3'd2,
        UART_TX_PAR   = 3'd3,
        UART_TX_STOP  = 3'd4
    } uart_tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int UART_DEFAULT_CLK_DIV = 434;

    // Zero-extension to 9 bits leaves the XOR parity unchanged.
    function automatic logic parity_bit(input logic [8:0] word, input int mode);
        return (mode == PAR_ODD) ? ~(^word) : ^word;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running bit timer with one-cycle tick at CLK_DIV-1
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = UART_DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // The tick is not masked by clear: a clear on the boundary cycle still ends that bit.
    assign bit_tick = enable && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - parametrised UART transmitter with valid/ready input
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = UART_DEFAULT_CLK_DIV,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done_sig,
    output logic                 tx_pin_out
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_core: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_core: CLK_DIV must be at least 2");
    end

    localparam logic [2:0] ST_IDLE  = UART_TX_IDLE;
    localparam logic [2:0] ST_START = UART_TX_START;
    localparam logic [2:0] ST_DATA  = UART_TX_DATA;
    localparam logic [2:0] ST_PAR   = UART_TX_PAR;
    localparam logic [2:0] ST_STOP  = UART_TX_STOP;

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    logic [2:0]           state_q,   state_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_q,    stop_d;
    logic                 par_q,     par_d;
    logic                 pin_q,     pin_d;

    logic bit_tick;
    logic accept;
    logic frame_end;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .enable   (state_q != ST_IDLE),
        .bit_tick (bit_tick)
    );

    assign frame_end   = (state_q == ST_STOP) && bit_tick && (stop_q == STOP_LAST);
    assign tx_ready    = (state_q == ST_IDLE) || frame_end;
    assign accept      = tx_valid && tx_ready;
    assign tx_busy     = (state_q != ST_IDLE);
    assign tx_done_sig = frame_end;
    assign tx_pin_out  = pin_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        stop_d    = stop_q;
        par_d     = par_q;
        case (state_q)
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // Parity taken from the word as latched, so later tx_data changes cannot leak in.
        if (accept) begin
            state_d   = ST_START;
            shift_d   = tx_data;
            par_d     = parity_bit(9'(tx_data), PARITY);
            bit_idx_d = '0;
            stop_d    = 1'b0;
        end
    end

    // Pin is registered from next-state values so the line changes in step with the state.
    always_comb begin
        pin_d = 1'b1;
        case (state_d)
            ST_START: pin_d = 1'b0;
            ST_DATA:  pin_d = shift_d[0];
            ST_PAR:   pin_d = par_d;
            default:  pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            stop_q    <= 1'b0;
            par_q     <= 1'b0;
            pin_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            stop_q    <= stop_d;
            par_q     <= par_d;
            pin_q     <= pin_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed self-checking bench for uart_tx_core
module tb_uart_tx_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]       vld = '0;
    logic [3:0][8:0]  dat = '0;
    logic [3:0]       rdy, bsy, dn, pin;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // 0: 8N1 CLK_DIV=434, 1: 7E2 CLK_DIV=4, 2: 7O2 CLK_DIV=4, 3: 8N1 CLK_DIV=4
    uart_tx_core u_dut0 (
        .clk(clk), .rst(rst), .tx_data(dat[0][7:0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_busy(bsy[0]), .tx_done_sig(dn[0]), .tx_pin_out(pin[0])
    );
    uart_tx_core #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(dat[1][6:0]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_busy(bsy[1]), .tx_done_sig(dn[1]), .tx_pin_out(pin[1])
    );
    uart_tx_core #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(dat[2][6:0]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_busy(bsy[2]), .tx_done_sig(dn[2]), .tx_pin_out(pin[2])
    );
    uart_tx_core #(.CLK_DIV(4)) u_dut3 (
        .clk(clk), .rst(rst), .tx_data(dat[3][7:0]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx_busy(bsy[3]), .tx_done_sig(dn[3]), .tx_pin_out(pin[3])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first clock after accept (T+1); returns in the final clock (T+F).
    // par < 0 means no parity bit. poke > 0 drives a stray word/valid in that clock.
    task automatic check_frame(input int i, input int d, input int nb, input int par,
                               input int nstop, input logic [8:0] w, input int poke,
                               input string tag);
        int nbit;
        int f;
        int k;
        logic e;
        nbit = 1 + nb + ((par >= 0) ? 1 : 0) + nstop;
        f    = d * nbit;
        for (int c = 1; c <= f; c++) begin
            if (c == 1) begin
                chk({tag, " start_first"}, pin[i], 1'b0);
                chk({tag, " busy_first"}, bsy[i], 1'b1);
            end
            if (((c - 1) % d) == d / 2) begin
                k = (c - 1) / d;
                if (k == 0)                       e = 1'b0;
                else if (k <= nb)                 e = w[k-1];
                else if (k == nb + 1 && par >= 0) e = par[0];
                else                              e = 1'b1;
                chk($sformatf("%s bit%0d", tag, k), pin[i], e);
                chk($sformatf("%s busy%0d", tag, k), bsy[i], 1'b1);
                chk($sformatf("%s ready%0d", tag, k), rdy[i], 1'b0);
            end
            if (c == f - 1) begin
                chk({tag, " done_early"}, dn[i], 1'b0);
                chk({tag, " ready_early"}, rdy[i], 1'b0);
            end
            if (c == f) begin
                chk({tag, " done"}, dn[i], 1'b1);
                chk({tag, " ready_end"}, rdy[i], 1'b1);
                chk({tag, " busy_end"}, bsy[i], 1'b1);
            end
            if (poke > 0 && c == poke) begin
                vld[i] = 1'b1;
                dat[i] = ~w;
            end
            if (poke > 0 && c == poke + 1) begin
                vld[i] = 1'b0;
            end
            if (c < f) tick();
        end
    endtask

    task automatic start_word(input int i, input logic [8:0] w);
        vld[i] = 1'b1;
        dat[i] = w;
        tick();
        vld[i] = 1'b0;
    endtask

    task automatic check_idle(input int i, input string tag);
        chk({tag, " pin"}, pin[i], 1'b1);
        chk({tag, " ready"}, rdy[i], 1'b1);
        chk({tag, " busy"}, bsy[i], 1'b0);
        chk({tag, " done"}, dn[i], 1'b0);
    endtask

    initial begin
        logic [8:0] w;
        logic saw;
        repeat (3) tick();
        check_idle(0, "rst0");
        check_idle(3, "rst3");
        rst = 1'b0;
        tick();

        // 8N1, CLK_DIV=434, 0xA5: done at T+4340
        start_word(0, 9'h0A5);
        check_frame(0, 434, 8, -1, 1, 9'h0A5, 0, "a5");
        tick();
        check_idle(0, "a5_after");

        // 7 data bits, two stops, 0x55 has four ones: even parity 0, odd parity 1
        start_word(1, 9'h055);
        check_frame(1, 4, 7, 0, 2, 9'h055, 0, "even55");
        tick();
        check_idle(1, "even_after");
        start_word(2, 9'h055);
        check_frame(2, 4, 7, 1, 2, 9'h055, 0, "odd55");
        tick();
        check_idle(2, "odd_after");

        // Back-to-back with tx_valid held high
        vld[3] = 1'b1;
        dat[3] = 9'h001;
        tick();
        dat[3] = 9'h002;
        check_frame(3, 4, 8, -1, 1, 9'h001, 0, "b2b1");
        tick();
        dat[3] = 9'h003;
        check_frame(3, 4, 8, -1, 1, 9'h002, 0, "b2b2");
        tick();
        vld[3] = 1'b0;
        dat[3] = 9'h0FF;
        check_frame(3, 4, 8, -1, 1, 9'h003, 0, "b2b3");
        tick();
        check_idle(3, "b2b_after");

        // Stray data/valid mid-frame is ignored
        start_word(3, 9'h03C);
        dat[3] = 9'h0C3;
        check_frame(3, 4, 8, -1, 1, 9'h03C, 14, "poke");
        tick();
        saw = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bsy[3] !== 1'b0 || pin[3] !== 1'b1) saw = 1'b1;
            tick();
        end
        chk("poke_no_extra_frame", saw, 1'b0);

        // Reset during data bit 3 (bit slot 4 = cycles T+17..T+20)
        start_word(3, 9'h096);
        repeat (17) tick();
        chk("rst_mid_pin_low_bit3", pin[3], 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle(3, "rst_mid");
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (dn[3] !== 1'b0) saw = 1'b1;
            tick();
        end
        chk("rst_mid_no_done", saw, 1'b0);
        start_word(3, 9'h05A);
        check_frame(3, 4, 8, -1, 1, 9'h05A, 0, "post_rst");
        tick();

        // Random words through the bit-centre decoder
        for (int n = 0; n < 20; n++) begin
            w = 9'($urandom_range(0, 255));
            start_word(3, w);
            check_frame(3, 4, 8, -1, 1, w, 0, $sformatf("rnd%0d", n));
            tick();
        end
        check_idle(3, "final");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
